// File: rtl/result_buffer_manager_pkg.sv
// Shared types and sizing for the result buffer manager.
package result_buffer_manager_pkg;

    localparam int RESULT_BUFFER_SIZE    = 8;
    localparam int RESULT_BUFFER_ID_SIZE = $clog2(RESULT_BUFFER_SIZE);

    typedef logic [31:0] ResultBufferEntryType;

    typedef enum logic {
        RB_IDLE,
        RB_FLUSH
    } RBMgrStateType;

endpackage

// File: rtl/result_buffer_manager_rb_free_finder.sv
// Priority encoder: lowest unallocated entry index plus an any-free flag.
module rb_free_finder #(
    parameter int RB_SIZE = 8,
    parameter int RB_ID_W = 3
) (
    input  logic [RB_SIZE-1:0] alloc_vec,
    output logic [RB_ID_W-1:0] free_idx,
    output logic               any_free
);

    // Walk from the top down so the lowest free index is the one that sticks.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = RB_SIZE - 1; i >= 0; i--) begin
            if (!alloc_vec[i]) begin
                free_idx = RB_ID_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/result_buffer_manager.sv
// Result buffer allocator with write-back, read port, release and sequential flush.
// Define RB_WR_BYPASS_EN to forward a same-cycle write onto the read port.
module result_buffer_manager
    import result_buffer_manager_pkg::*;
#(
    parameter int RB_SIZE = RESULT_BUFFER_SIZE,
    parameter int RB_ID_W = RESULT_BUFFER_ID_SIZE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_req,
    output logic               alloc_gnt,
    output logic [RB_ID_W-1:0] alloc_idx,
    input  logic               wr_en,
    input  logic [RB_ID_W-1:0] wr_idx,
    input  logic [31:0]        wr_data,
    input  logic [RB_ID_W-1:0] rd_idx,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    input  logic               rel_en,
    input  logic [RB_ID_W-1:0] rel_idx,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic [RB_ID_W:0]   free_count,
    output logic               full
);

    localparam logic [RB_ID_W:0] COUNT_ONE  = (RB_ID_W+1)'(1);
    localparam logic [RB_ID_W:0] COUNT_FULL = (RB_ID_W+1)'(RB_SIZE);

    logic [RB_SIZE-1:0]                       alloc_vec_q, alloc_vec_d;
    logic [RB_SIZE-1:0]                       valid_vec_q, valid_vec_d;
    ResultBufferEntryType [RB_SIZE-1:0]       data_q, data_d;
    RBMgrStateType                            state_q, state_d;
    logic [RB_ID_W-1:0]                       flush_ptr_q, flush_ptr_d;
    logic [RB_ID_W:0]                         free_count_q, free_count_d;

    logic [RB_ID_W-1:0] free_idx;
    logic               any_free;
    logic               is_idle;
    logic               rel_hit;
    logic               wr_hit;

    rb_free_finder #(
        .RB_SIZE (RB_SIZE),
        .RB_ID_W (RB_ID_W)
    ) u_free_finder (
        .alloc_vec (alloc_vec_q),
        .free_idx  (free_idx),
        .any_free  (any_free)
    );

    assign is_idle    = (state_q == RB_IDLE);
    assign full       = (free_count_q == '0);
    assign free_count = free_count_q;
    assign flush_busy = (state_q == RB_FLUSH);
    assign alloc_idx  = free_idx;
    assign alloc_gnt  = alloc_req & ~full & any_free & is_idle & ~flush_req;

    // Release beats a write to the same entry in the same cycle.
    assign rel_hit = is_idle & rel_en & alloc_vec_q[rel_idx];
    assign wr_hit  = is_idle & wr_en & alloc_vec_q[wr_idx]
                   & ~(rel_hit & (rel_idx == wr_idx));

    always_comb begin
        rd_valid = alloc_vec_q[rd_idx] & valid_vec_q[rd_idx];
        rd_data  = rd_valid ? data_q[rd_idx] : '0;
`ifdef RB_WR_BYPASS_EN
        if (wr_hit && (wr_idx == rd_idx)) begin
            rd_valid = 1'b1;
            rd_data  = wr_data;
        end
`endif
    end

    always_comb begin
        alloc_vec_d  = alloc_vec_q;
        valid_vec_d  = valid_vec_q;
        data_d       = data_q;
        state_d      = state_q;
        flush_ptr_d  = flush_ptr_q;
        free_count_d = free_count_q;
        case (state_q)
            RB_IDLE: begin
                if (wr_hit) begin
                    data_d[wr_idx]      = wr_data;
                    valid_vec_d[wr_idx] = 1'b1;
                end
                if (rel_hit) begin
                    alloc_vec_d[rel_idx] = 1'b0;
                    valid_vec_d[rel_idx] = 1'b0;
                end
                if (alloc_gnt) begin
                    alloc_vec_d[free_idx] = 1'b1;
                    valid_vec_d[free_idx] = 1'b0;
                end
                if (alloc_gnt && !rel_hit) begin
                    free_count_d = free_count_q - COUNT_ONE;
                end else if (rel_hit && !alloc_gnt) begin
                    free_count_d = free_count_q + COUNT_ONE;
                end
                if (flush_req) begin
                    state_d     = RB_FLUSH;
                    flush_ptr_d = '0;
                end
            end
            RB_FLUSH: begin
                alloc_vec_d[flush_ptr_q] = 1'b0;
                valid_vec_d[flush_ptr_q] = 1'b0;
                data_d[flush_ptr_q]      = '0;
                flush_ptr_d              = flush_ptr_q + RB_ID_W'(1);
                if (flush_ptr_q == RB_ID_W'(RB_SIZE - 1)) begin
                    state_d      = RB_IDLE;
                    flush_ptr_d  = '0;
                    free_count_d = COUNT_FULL;
                end
            end
            default: begin
                state_d = RB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_vec_q  <= '0;
            valid_vec_q  <= '0;
            data_q       <= '0;
            state_q      <= RB_IDLE;
            flush_ptr_q  <= '0;
            free_count_q <= COUNT_FULL;
        end else begin
            alloc_vec_q  <= alloc_vec_d;
            valid_vec_q  <= valid_vec_d;
            data_q       <= data_d;
            state_q      <= state_d;
            flush_ptr_q  <= flush_ptr_d;
            free_count_q <= free_count_d;
        end
    end

endmodule

// File: tb/tb_result_buffer_manager.sv
// Self-checking bench: directed scenarios plus random traffic against an entry-level model.
module tb_result_buffer_manager;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [2:0]  alloc_idx;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data;
    logic [2:0]  rd_idx;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rel_en;
    logic [2:0]  rel_idx;
    logic        flush_req;
    logic        flush_busy;
    logic [3:0]  free_count;
    logic        full;

    int total = 0;
    int bad   = 0;

    bit          m_alloc [N];
    bit          m_valid [N];
    logic [31:0] m_data  [N];
    int          flush_left;

    always #5 clk = ~clk;

    result_buffer_manager dut (
        .clk        (clk),
        .reset      (reset),
        .alloc_req  (alloc_req),
        .alloc_gnt  (alloc_gnt),
        .alloc_idx  (alloc_idx),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rel_en     (rel_en),
        .rel_idx    (rel_idx),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .free_count (free_count),
        .full       (full)
    );

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) begin
            if (!m_alloc[i]) return i;
        end
        return -1;
    endfunction

    function automatic int free_entries();
        int n = 0;
        for (int i = 0; i < N; i++) begin
            if (!m_alloc[i]) n++;
        end
        return n;
    endfunction

    function automatic bit write_lands();
        return wr_en && m_alloc[wr_idx] && !(rel_en && rel_idx == wr_idx);
    endfunction

    task automatic resetModel();
        for (int i = 0; i < N; i++) begin
            m_alloc[i] = 1'b0;
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
        end
        flush_left = 0;
    endtask

    task automatic applyStimulus(input bit a_req, input bit w_en, input logic [2:0] w_idx,
                                 input logic [31:0] w_data, input logic [2:0] r_idx,
                                 input bit rl_en, input logic [2:0] rl_idx, input bit f_req);
        alloc_req = a_req;
        wr_en     = w_en;
        wr_idx    = w_idx;
        wr_data   = w_data;
        rd_idx    = r_idx;
        rel_en    = rl_en;
        rel_idx   = rl_idx;
        flush_req = f_req;
    endtask

    task automatic checkOutput();
        int          lf;
        bit          idle;
        bit          exp_gnt;
        bit          exp_rv;
        logic [31:0] exp_rd;
        lf      = lowest_free();
        idle    = (flush_left == 0);
        exp_gnt = alloc_req && idle && !flush_req && (lf >= 0);
        checkValue("alloc_gnt", 32'(alloc_gnt), 32'(exp_gnt));
        checkValue("alloc_idx", 32'(alloc_idx), (lf < 0) ? 32'd0 : 32'(lf));
        checkValue("flush_busy", 32'(flush_busy), 32'(!idle));
        if (idle) begin
            checkValue("free_count", 32'(free_count), 32'(free_entries()));
            checkValue("full", 32'(full), 32'(free_entries() == 0));
        end
        exp_rv = m_alloc[rd_idx] && m_valid[rd_idx];
        exp_rd = exp_rv ? m_data[rd_idx] : 32'd0;
`ifdef RB_WR_BYPASS_EN
        if (idle && write_lands() && wr_idx == rd_idx) begin
            exp_rv = 1'b1;
            exp_rd = wr_data;
        end
`endif
        checkValue("rd_valid", 32'(rd_valid), 32'(exp_rv));
        checkValue("rd_data", rd_data, exp_rd);
    endtask

    task automatic updateModel();
        int lf;
        bit g;
        bit r;
        bit w;
        if (flush_left == 0) begin
            lf = lowest_free();
            g  = alloc_req && !flush_req && (lf >= 0);
            r  = rel_en && m_alloc[rel_idx];
            w  = write_lands();
            if (w) begin
                m_data[wr_idx]  = wr_data;
                m_valid[wr_idx] = 1'b1;
            end
            if (r) begin
                m_alloc[rel_idx] = 1'b0;
                m_valid[rel_idx] = 1'b0;
            end
            if (g) begin
                m_alloc[lf] = 1'b1;
                m_valid[lf] = 1'b0;
            end
            if (flush_req) flush_left = N;
        end else begin
            m_alloc[N - flush_left] = 1'b0;
            m_valid[N - flush_left] = 1'b0;
            m_data[N - flush_left]  = '0;
            flush_left--;
        end
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic finishCycle();
        checkOutput();
        updateModel();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        finishCycle();
    endtask

    task automatic idleStim();
        applyStimulus(0, 0, 3'd0, 32'd0, 3'd0, 0, 3'd0, 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idleStim();
        @(posedge clk);
        #1;
        reset = 1'b0;
        resetModel();
    endtask

    initial begin
        reset = 1'b1;
        idleStim();
        resetModel();
        @(posedge clk);
        #1;
        doReset();

        $display("[TB] reset state");
        settle();
        checkValue("rst_free_count", 32'(free_count), 32'd8);
        checkValue("rst_full", 32'(full), 32'd0);
        checkValue("rst_flush_busy", 32'(flush_busy), 32'd0);
        checkValue("rst_rd_valid", 32'(rd_valid), 32'd0);
        checkValue("rst_rd_data", rd_data, 32'd0);
        finishCycle();

        $display("[TB] back-to-back allocation");
        for (int i = 0; i < N; i++) begin
            applyStimulus(1, 0, 3'd0, 32'd0, 3'd0, 0, 3'd0, 0);
            settle();
            checkValue("t1_gnt", 32'(alloc_gnt), 32'd1);
            checkValue("t1_idx", 32'(alloc_idx), 32'(i));
            finishCycle();
        end
        settle();
        checkValue("t1_full", 32'(full), 32'd1);
        checkValue("t1_free_count", 32'(free_count), 32'd0);
        checkValue("t1_ninth_gnt", 32'(alloc_gnt), 32'd0);
        finishCycle();

        $display("[TB] write then read");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 3'd0, 32'd0, 3'd0, 0, 3'd0, 0);
            cycle();
        end
        applyStimulus(0, 1, 3'd3, 32'hDEADBEEF, 3'd3, 0, 3'd0, 0);
        settle();
`ifndef RB_WR_BYPASS_EN
        checkValue("t2_same_cycle_rd_valid", 32'(rd_valid), 32'd0);
`endif
        finishCycle();
        applyStimulus(0, 0, 3'd0, 32'd0, 3'd3, 0, 3'd0, 0);
        settle();
        checkValue("t2_rd_valid", 32'(rd_valid), 32'd1);
        checkValue("t2_rd_data", rd_data, 32'hDEADBEEF);
        finishCycle();

        $display("[TB] release and re-grant");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 3'd0, 32'd0, 3'd0, 0, 3'd0, 0);
            cycle();
        end
        applyStimulus(1, 0, 3'd0, 32'd0, 3'd0, 1, 3'd5, 0);
        settle();
        checkValue("t3_gnt_on_release", 32'(alloc_gnt), 32'd0);
        finishCycle();
        applyStimulus(1, 0, 3'd0, 32'd0, 3'd0, 0, 3'd0, 0);
        settle();
        checkValue("t3_regrant_gnt", 32'(alloc_gnt), 32'd1);
        checkValue("t3_regrant_idx", 32'(alloc_idx), 32'd5);
        finishCycle();

        $display("[TB] write/release collision and dropped write");
        applyStimulus(0, 1, 3'd2, 32'h0000AAAA, 3'd0, 1, 3'd2, 0);
        cycle();
        applyStimulus(0, 0, 3'd0, 32'd0, 3'd2, 1, 3'd6, 0);
        settle();
        checkValue("t4_collide_rd_valid", 32'(rd_valid), 32'd0);
        finishCycle();
        applyStimulus(0, 1, 3'd6, 32'h00005555, 3'd6, 0, 3'd0, 0);
        cycle();
        applyStimulus(0, 0, 3'd0, 32'd0, 3'd6, 0, 3'd0, 0);
        settle();
        checkValue("t4_free_write_rd_valid", 32'(rd_valid), 32'd0);
        checkValue("t4_free_count", 32'(free_count), 32'd2);
        finishCycle();

        $display("[TB] flush");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 3'd0, 32'd0, 3'd0, 0, 3'd0, 0);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 3'(i), 32'h100 + 32'(i), 3'(i), 0, 3'd0, 0);
            cycle();
        end
        applyStimulus(1, 0, 3'd0, 32'd0, 3'd0, 0, 3'd0, 1);
        settle();
        checkValue("t5_gnt_with_flush_req", 32'(alloc_gnt), 32'd0);
        finishCycle();
        for (int i = 0; i < N; i++) begin
            applyStimulus(1, 1, 3'd0, 32'hFFFF, 3'd0, 0, 3'd0, 0);
            settle();
            checkValue("t5_flush_busy", 32'(flush_busy), 32'd1);
            checkValue("t5_flush_gnt", 32'(alloc_gnt), 32'd0);
            finishCycle();
        end
        idleStim();
        settle();
        checkValue("t5_busy_done", 32'(flush_busy), 32'd0);
        checkValue("t5_free_count", 32'(free_count), 32'd8);
        finishCycle();
        for (int i = 0; i < N; i++) begin
            applyStimulus(0, 0, 3'd0, 32'd0, 3'(i), 0, 3'd0, 0);
            settle();
            checkValue("t5_rd_valid", 32'(rd_valid), 32'd0);
            finishCycle();
        end

        $display("[TB] write bypass");
        doReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 3'd0, 32'd0, 3'd0, 0, 3'd0, 0);
            cycle();
        end
        applyStimulus(0, 1, 3'd1, 32'h1111, 3'd1, 0, 3'd0, 0);
        cycle();
        applyStimulus(0, 1, 3'd1, 32'h1234, 3'd1, 0, 3'd0, 0);
        settle();
`ifdef RB_WR_BYPASS_EN
        checkValue("t6_bypass_rd_data", rd_data, 32'h1234);
`else
        checkValue("t6_nobypass_rd_data", rd_data, 32'h1111);
`endif
        checkValue("t6_rd_valid", 32'(rd_valid), 32'd1);
        finishCycle();

        $display("[TB] reset during flush");
        applyStimulus(0, 0, 3'd0, 32'd0, 3'd0, 0, 3'd0, 1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            idleStim();
            cycle();
        end
        doReset();
        applyStimulus(1, 0, 3'd0, 32'd0, 3'd1, 0, 3'd0, 0);
        settle();
        checkValue("t7_busy", 32'(flush_busy), 32'd0);
        checkValue("t7_free_count", 32'(free_count), 32'd8);
        checkValue("t7_gnt", 32'(alloc_gnt), 32'd1);
        checkValue("t7_idx", 32'(alloc_idx), 32'd0);
        checkValue("t7_rd_valid", 32'(rd_valid), 32'd0);
        finishCycle();

        $display("[TB] random traffic");
        for (int c = 0; c < 800; c++) begin
            applyStimulus($urandom_range(0, 99) < 55,
                          $urandom_range(0, 99) < 50,
                          3'($urandom_range(0, N - 1)),
                          $urandom,
                          3'($urandom_range(0, N - 1)),
                          $urandom_range(0, 99) < 40,
                          3'($urandom_range(0, N - 1)),
                          $urandom_range(0, 99) < 2);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
